// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, halfword
// write-mask constants and the halfword merge helper.
package dmem_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } dmem_state_e;

    // Halfword write enables: bit0 covers [15:0], bit1 covers [31:16]
    localparam logic [1:0] MaskNone = 2'b00;
    localparam logic [1:0] MaskLo   = 2'b01;
    localparam logic [1:0] MaskHi   = 2'b10;
    localparam logic [1:0] MaskAll  = 2'b11;

    localparam int unsigned DataW = 32;

    // Replace only the halves selected by mask; unselected halves keep old data
    function automatic logic [DataW-1:0] merge_halves(
        input logic [DataW-1:0] old_word,
        input logic [DataW-1:0] new_word,
        input logic [1:0]       mask
    );
        logic [DataW-1:0] merged;
        merged = old_word;
        if ((mask & MaskLo) != MaskNone) merged[15:0]  = new_word[15:0];
        if ((mask & MaskHi) != MaskNone) merged[31:16] = new_word[31:16];
        return merged;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data memory: one halfword-masked write port, two
// asynchronous read ports (access and display), cleared by async reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DataW-1:0]  wdata,
    input  logic [1:0]        wmask,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DataW-1:0]  rdata,
    input  logic [ADDR_W-1:0] disp_raddr,
    output logic [DataW-1:0]  disp_rdata
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [DataW-1:0] mem [Depth];

    // Masked write; the whole array is cleared on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= merge_halves(mem[waddr], wdata, wmask);
        end
    end

    assign rdata      = mem[raddr];
    assign disp_rdata = mem[disp_raddr];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder with configurable wait states.
// Optional access statistics (rd_count/wr_count) when DMEM_STATS_EN is defined.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_W      = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_mask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [31:0]       disp_data,
    output logic              busy
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
`endif
);

    localparam bit         NoWait   = (WAIT_CYCLES == 0);
    // Counter value in the final wait cycle; unused when NoWait
    localparam logic [3:0] WaitLast = NoWait ? 4'd0 : 4'(WAIT_CYCLES - 1);

    dmem_state_e       state_q;
    logic [3:0]        wait_cnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        mask_q;

    logic              accept;
    logic              enter_resp;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [31:0]       cmd_wdata;
    logic [1:0]        cmd_mask;
    logic              mem_we;
    logic [31:0]       acc_rdata;
    logic [31:0]       disp_rdata;
    logic [31:0]       resp_rdata_d;

    assign accept = req_valid & req_ready;

    // With no wait states the command commits straight from the request inputs
    // on the accept edge; otherwise it commits from the latched copy on the
    // edge that leaves the last wait cycle.
    assign enter_resp = NoWait ? accept
                               : ((state_q == StWait) && (wait_cnt_q == WaitLast));
    assign cmd_we     = NoWait ? req_we    : we_q;
    assign cmd_addr   = NoWait ? req_addr  : addr_q;
    assign cmd_wdata  = NoWait ? req_wdata : wdata_q;
    assign cmd_mask   = NoWait ? req_mask  : mask_q;
    assign mem_we     = enter_resp & cmd_we;

    // Response reflects the word as it will be after the store commits
    assign resp_rdata_d = cmd_we ? merge_halves(acc_rdata, cmd_wdata, cmd_mask) : acc_rdata;

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .we         (mem_we),
        .waddr      (cmd_addr),
        .wdata      (cmd_wdata),
        .wmask      (cmd_mask),
        .raddr      (cmd_addr),
        .rdata      (acc_rdata),
        .disp_raddr (disp_addr),
        .disp_rdata (disp_rdata)
    );

    // Request/response FSM with registered handshake and status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            wait_cnt_q <= 4'd0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mask_q     <= MaskNone;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            busy       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        we_q      <= req_we;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        mask_q    <= req_mask;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (NoWait) begin
                            state_q    <= StResp;
                            resp_valid <= 1'b1;
                            resp_rdata <= resp_rdata_d;
                        end else begin
                            state_q    <= StWait;
                            wait_cnt_q <= 4'd0;
                        end
                    end
                end
                StWait: begin
                    if (wait_cnt_q == WaitLast) begin
                        state_q    <= StResp;
                        wait_cnt_q <= 4'd0;
                        resp_valid <= 1'b1;
                        resp_rdata <= resp_rdata_d;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 4'd1;
                    end
                end
                StResp: begin
                    // Handshake edge returns to idle; no accept is possible here
                    if (resp_ready) begin
                        state_q    <= StIdle;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    wait_cnt_q <= 4'd0;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    // Display port: registered every cycle, sees a same-edge store one cycle later
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_data <= '0;
        end else begin
            disp_data <= disp_rdata;
        end
    end

`ifdef DMEM_STATS_EN
    // Saturating counters of accepted loads and stores
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (accept) begin
            if (!req_we && (rd_count != 32'hFFFF_FFFF)) rd_count <= rd_count + 32'd1;
            if (req_we && (wr_count != 32'hFFFF_FFFF))  wr_count <= wr_count + 32'd1;
        end
    end
`endif

endmodule
